// File: rtl/port_trace_pkg.sv
// Shared constants for the port trace monitor: done-cause codes and the
// layout of a packed trace entry {port_id, data, timestamp}.
package port_trace_pkg;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_DONE  = 2'b01;
    localparam logic [1:0] CAUSE_LIMIT = 2'b10;
    localparam logic [1:0] CAUSE_BOTH  = 2'b11;

    // Timestamp occupies the least significant bits of an entry
    localparam int TS_LSB = 0;

    function automatic int entry_width(input int port_w, input int data_w, input int ts_w);
        return port_w + data_w + ts_w;
    endfunction

    function automatic int data_lsb(input int ts_w);
        return TS_LSB + ts_w;
    endfunction

    function automatic int port_lsb(input int data_w, input int ts_w);
        return TS_LSB + ts_w + data_w;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is presented on dout whenever
// the FIFO holds data. A push into a full FIFO only succeeds alongside a pop.
module sync_fifo_fwft #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags and the push/pop requests that actually take effect
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        pop_ok_s  = pop && !empty_s;
        push_ok_s = push && (!full_s || pop_ok_s);
    end

    // Next occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_next_s;
        end
    end

    // Head entry, forced to zero when nothing is stored
    always_comb begin
        if (empty_s) begin
            dout = {WIDTH{1'b0}};
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/port_trace_monitor.sv
// Watches a KCPSM3-style output bus, timestamps and buffers matching writes,
// and raises a sticky done flag on a DONE-port write or a cycle limit.
module port_trace_monitor
    import port_trace_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                PORT_W      = 8,
    parameter int                TS_W        = 16,
    parameter int                DEPTH       = 16,
    parameter logic [PORT_W-1:0] MATCH_ID    = 8'h00,
    parameter logic [PORT_W-1:0] MATCH_MASK  = 8'h00,
    parameter logic [PORT_W-1:0] DONE_ID     = 8'hFF,
    parameter int                CYCLE_LIMIT = 50,
    localparam int               CW          = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PORT_W-1:0] port_id,
    input  logic [DATA_W-1:0] out_port,
    input  logic              write_strobe,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [PORT_W-1:0] rd_port_id,
    output logic [DATA_W-1:0] rd_data,
    output logic [TS_W-1:0]   rd_ts,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              done,
    output logic [1:0]        done_cause
);

    localparam int EW       = entry_width(PORT_W, DATA_W, TS_W);
    localparam int DATA_LSB = data_lsb(TS_W);
    localparam int PORT_LSB = port_lsb(DATA_W, TS_W);

    localparam logic [TS_W-1:0] TS_MAX = {TS_W{1'b1}};
    // A limit the counter can never reach is treated as disabled
    localparam bit LIMIT_EN =
        (CYCLE_LIMIT != 0) && (longint'(CYCLE_LIMIT) <= longint'(TS_MAX));
    localparam logic [TS_W-1:0] LIMIT_VAL = TS_W'(CYCLE_LIMIT);

    logic [TS_W-1:0] cyc_r;
    logic            done_r;
    logic [1:0]      cause_r;
    logic            overflow_r;

    logic            match_s;
    logic            done_hit_s;
    logic            limit_hit_s;
    logic [1:0]      cause_next_s;
    logic [EW-1:0]   entry_s;
    logic [EW-1:0]   head_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;

    // Capture qualification and end-of-trace triggers
    always_comb begin
        match_s     = 1'b0;
        done_hit_s  = 1'b0;
        limit_hit_s = 1'b0;
        if (write_strobe && ((port_id & MATCH_MASK) == (MATCH_ID & MATCH_MASK)) && !done_r) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
        if (write_strobe && (port_id == DONE_ID)) begin
            done_hit_s = 1'b1;
        end else begin
            done_hit_s = 1'b0;
        end
        if (LIMIT_EN && (cyc_r == LIMIT_VAL)) begin
            limit_hit_s = 1'b1;
        end else begin
            limit_hit_s = 1'b0;
        end
    end

    // Cause code latched on the rising edge of done
    always_comb begin
        cause_next_s = CAUSE_NONE;
        case ({limit_hit_s, done_hit_s})
            2'b11:   cause_next_s = CAUSE_BOTH;
            2'b10:   cause_next_s = CAUSE_LIMIT;
            2'b01:   cause_next_s = CAUSE_DONE;
            default: cause_next_s = CAUSE_NONE;
        endcase
    end

    // Saturating cycle counter, frozen once the trace has ended
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_r <= {TS_W{1'b0}};
        end else if (!done_r && (cyc_r != TS_MAX)) begin
            cyc_r <= cyc_r + TS_W'(1'b1);
        end
    end

    // Sticky done flag and its cause
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_r  <= 1'b0;
            cause_r <= CAUSE_NONE;
        end else if (!done_r && (done_hit_s || limit_hit_s)) begin
            done_r  <= 1'b1;
            cause_r <= cause_next_s;
        end
    end

    // Sticky overflow: a full FIFO without a same-cycle pop drops the write
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (match_s && fifo_full_s && !rd_en) begin
            overflow_r <= 1'b1;
        end
    end

    assign entry_s = {port_id, out_port, cyc_r};

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (match_s),
        .pop   (rd_en),
        .din   (entry_s),
        .dout  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign rd_valid   = !fifo_empty_s;
    assign rd_port_id = head_s[PORT_LSB +: PORT_W];
    assign rd_data    = head_s[DATA_LSB +: DATA_W];
    assign rd_ts      = head_s[TS_LSB +: TS_W];
    assign count      = fifo_count_s;
    assign overflow   = overflow_r;
    assign done       = done_r;
    assign done_cause = cause_r;

endmodule

// File: tb/tb_port_trace_monitor.sv
// Bench for port_trace_monitor: three differently configured instances share
// one stimulus stream; a queue-based model checks all of them every cycle.
module tb_port_trace_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic       rd_en = 1'b0;

    always #5 clk = ~clk;

    // Instance A: capture all, DEPTH 16, no limit
    logic a_rd_valid, a_overflow, a_done;
    logic [7:0] a_rd_port_id, a_rd_data;
    logic [15:0] a_rd_ts;
    logic [4:0] a_count;
    logic [1:0] a_done_cause;
    // Instance B: ports 0x4?, DEPTH 4, limit 20
    logic b_rd_valid, b_overflow, b_done;
    logic [7:0] b_rd_port_id, b_rd_data;
    logic [15:0] b_rd_ts;
    logic [2:0] b_count;
    logic [1:0] b_done_cause;
    // Instance C: ports 0x?3, DEPTH 2, 3-bit timestamp, DONE at 0x52
    logic c_rd_valid, c_overflow, c_done;
    logic [7:0] c_rd_port_id, c_rd_data;
    logic [2:0] c_rd_ts;
    logic [1:0] c_count;
    logic [1:0] c_done_cause;

    port_trace_monitor #(.DEPTH(16), .MATCH_ID(8'h00), .MATCH_MASK(8'h00),
                         .DONE_ID(8'hFF), .CYCLE_LIMIT(0)) dut_a (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .rd_en(rd_en), .rd_valid(a_rd_valid),
        .rd_port_id(a_rd_port_id), .rd_data(a_rd_data), .rd_ts(a_rd_ts),
        .count(a_count), .overflow(a_overflow), .done(a_done), .done_cause(a_done_cause));

    port_trace_monitor #(.DEPTH(4), .MATCH_ID(8'h40), .MATCH_MASK(8'hF0),
                         .DONE_ID(8'hFF), .CYCLE_LIMIT(20)) dut_b (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .rd_en(rd_en), .rd_valid(b_rd_valid),
        .rd_port_id(b_rd_port_id), .rd_data(b_rd_data), .rd_ts(b_rd_ts),
        .count(b_count), .overflow(b_overflow), .done(b_done), .done_cause(b_done_cause));

    port_trace_monitor #(.TS_W(3), .DEPTH(2), .MATCH_ID(8'h03), .MATCH_MASK(8'h0F),
                         .DONE_ID(8'h52), .CYCLE_LIMIT(0)) dut_c (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .rd_en(rd_en), .rd_valid(c_rd_valid),
        .rd_port_id(c_rd_port_id), .rd_data(c_rd_data), .rd_ts(c_rd_ts),
        .count(c_count), .overflow(c_overflow), .done(c_done), .done_cause(c_done_cause));

    // Per-instance views of the outputs for the generic checker
    logic        o_valid[3], o_ovf[3], o_done[3];
    logic [7:0]  o_pid[3], o_dat[3], o_cnt[3];
    logic [31:0] o_ts[3];
    logic [1:0]  o_cause[3];
    assign o_valid = '{a_rd_valid, b_rd_valid, c_rd_valid};
    assign o_ovf   = '{a_overflow, b_overflow, c_overflow};
    assign o_done  = '{a_done, b_done, c_done};
    assign o_pid   = '{a_rd_port_id, b_rd_port_id, c_rd_port_id};
    assign o_dat   = '{a_rd_data, b_rd_data, c_rd_data};
    assign o_cnt   = '{8'(a_count), 8'(b_count), 8'(c_count)};
    assign o_ts    = '{32'(a_rd_ts), 32'(b_rd_ts), 32'(c_rd_ts)};
    assign o_cause = '{a_done_cause, b_done_cause, c_done_cause};

    // Configuration of each instance, as seen by the model
    int         cfg_depth[3] = '{16, 4, 2};
    logic [7:0] cfg_mid[3]   = '{8'h00, 8'h40, 8'h03};
    logic [7:0] cfg_mask[3]  = '{8'h00, 8'hF0, 8'h0F};
    logic [7:0] cfg_done[3]  = '{8'hFF, 8'hFF, 8'h52};
    int         cfg_lim[3]   = '{0, 20, 0};
    int         cfg_tsmax[3] = '{65535, 65535, 7};

    typedef struct packed {
        logic [7:0]  pid;
        logic [7:0]  dat;
        logic [31:0] ts;
    } ent_t;

    ent_t mq[3][$];
    int   mcyc[3];
    bit   mdone[3];
    bit   movf[3];
    logic [1:0] mcause[3];
    bit   mvalid = 1'b0;
    int   cyc_now = 0;

    int n_checks = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input int inst,
                                input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst %0d] cyc=%0d: got %0h expected %0h",
                     nm, inst, cyc_now, act, exp);
        end
    endfunction

    // One clock edge of the reference model for instance i
    function automatic void model_step(input int i);
        bit m, dh, lh, was_done;
        ent_t e;
        if (!reset) begin
            mq[i].delete();
            mcyc[i] = 0;
            mdone[i] = 1'b0;
            movf[i] = 1'b0;
            mcause[i] = 2'b00;
        end else begin
            was_done = mdone[i];
            m  = write_strobe && ((port_id & cfg_mask[i]) == (cfg_mid[i] & cfg_mask[i])) && !was_done;
            dh = write_strobe && (port_id == cfg_done[i]);
            lh = (cfg_lim[i] != 0) && (mcyc[i] == cfg_lim[i]);
            if (rd_en && mq[i].size() > 0) void'(mq[i].pop_front());
            if (m) begin
                if (mq[i].size() < cfg_depth[i]) begin
                    e.pid = port_id;
                    e.dat = out_port;
                    e.ts  = mcyc[i];
                    mq[i].push_back(e);
                end else begin
                    movf[i] = 1'b1;
                end
            end
            if (!was_done && (dh || lh)) begin
                mdone[i] = 1'b1;
                if (dh && lh) mcause[i] = 2'b11;
                else if (lh) mcause[i] = 2'b10;
                else mcause[i] = 2'b01;
            end
            if (!was_done && mcyc[i] < cfg_tsmax[i]) mcyc[i]++;
        end
    endfunction

    function automatic void check_all();
        ent_t h;
        for (int i = 0; i < 3; i++) begin
            h = '0;
            if (mq[i].size() > 0) h = mq[i][0];
            chk("m_valid", i, 64'(o_valid[i]), 64'(mq[i].size() > 0));
            chk("m_count", i, 64'(o_cnt[i]), 64'(mq[i].size()));
            chk("m_pid", i, 64'(o_pid[i]), 64'(h.pid));
            chk("m_data", i, 64'(o_dat[i]), 64'(h.dat));
            chk("m_ts", i, 64'(o_ts[i]), 64'(h.ts));
            chk("m_ovf", i, 64'(o_ovf[i]), 64'(movf[i]));
            chk("m_done", i, 64'(o_done[i]), 64'(mdone[i]));
            chk("m_cause", i, 64'(o_cause[i]), 64'(mcause[i]));
        end
    endfunction

    // Check at the falling edge, advance the model at the rising edge
    task automatic cycle();
        @(negedge clk);
        if (mvalid) check_all();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        mvalid = 1'b1;
        if (!reset) cyc_now = 0;
        else cyc_now++;
        #1;
    endtask

    task automatic put(input logic ws, input logic [7:0] pid, input logic [7:0] d, input logic rd);
        write_strobe = ws;
        port_id = pid;
        out_port = d;
        rd_en = rd;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        write_strobe = 1'b0;
        rd_en = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic idle_to(input int k);
        for (int n = 0; n < 200 && cyc_now < k; n++) put(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic chk_head(input string nm, input int inst, input logic [7:0] pid,
                            input logic [7:0] d, input int ts);
        chk({nm, "_valid"}, inst, 64'(o_valid[inst]), 64'(1'b1));
        chk({nm, "_pid"}, inst, 64'(o_pid[inst]), 64'(pid));
        chk({nm, "_data"}, inst, 64'(o_dat[inst]), 64'(d));
        chk({nm, "_ts"}, inst, 64'(o_ts[inst]), 64'(ts));
    endtask

    typedef struct {
        logic       ws;
        logic [7:0] pid;
        logic [7:0] dat;
        logic       rd;
        logic       ev;
        int         ecnt;
        logic [7:0] epid;
        logic [7:0] edat;
        int         ets;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [7:0] pick;
        // Row k: inputs for cycle k and the outputs of instance A seen in cycle k
        tbl[0] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00, 0};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00, 0};
        tbl[2] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00, 0};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 0, 8'h00, 8'h00, 0};
        tbl[4] = '{1'b1, 8'h03, 8'h11, 1'b1, 1'b0, 0, 8'h00, 8'h00, 0};
        tbl[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1, 8'h03, 8'h11, 4};
        tbl[6] = '{1'b1, 8'h07, 8'h22, 1'b0, 1'b1, 1, 8'h03, 8'h11, 4};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2, 8'h03, 8'h11, 4};
        tbl[8] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1, 8'h07, 8'h22, 6};
        tbl[9] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00, 0};

        do_reset();
        chk("rst_done", 0, 64'(a_done), 64'(1'b0));
        chk("rst_cause", 0, 64'(a_done_cause), 64'(2'b00));
        chk("rst_ovf", 0, 64'(a_overflow), 64'(1'b0));

        // Basic capture and FWFT reads (rd_en while empty in cycles 3-4 is ignored)
        for (int k = 0; k < 10; k++) begin
            chk("tbl_valid", 0, 64'(a_rd_valid), 64'(tbl[k].ev));
            chk("tbl_count", 0, 64'(a_count), 64'(tbl[k].ecnt));
            chk("tbl_pid", 0, 64'(a_rd_port_id), 64'(tbl[k].epid));
            chk("tbl_data", 0, 64'(a_rd_data), 64'(tbl[k].edat));
            chk("tbl_ts", 0, 64'(a_rd_ts), 64'(tbl[k].ets));
            put(tbl[k].ws, tbl[k].pid, tbl[k].dat, tbl[k].rd);
        end

        // Mask filtering on instance B
        do_reset();
        idle_to(1);
        put(1'b1, 8'h41, 8'h01, 1'b0);
        put(1'b1, 8'h52, 8'h02, 1'b0);
        put(1'b1, 8'h4F, 8'h03, 1'b0);
        chk("mask_count", 1, 64'(b_count), 64'(2));
        chk_head("mask_h0", 1, 8'h41, 8'h01, 1);
        put(1'b0, 8'h00, 8'h00, 1'b1);
        chk_head("mask_h1", 1, 8'h4F, 8'h03, 3);
        put(1'b0, 8'h00, 8'h00, 1'b1);
        chk("mask_empty", 1, 64'(b_rd_valid), 64'(1'b0));

        // Overflow on the 4-deep instance, then push+pop while full
        do_reset();
        idle_to(1);
        for (int i = 0; i < 6; i++) put(1'b1, 8'(8'h40 + i), 8'(8'hA0 + i), 1'b0);
        chk("full_count", 1, 64'(b_count), 64'(4));
        chk("full_ovf", 1, 64'(b_overflow), 64'(1'b1));
        chk("a_count6", 0, 64'(a_count), 64'(6));
        chk_head("full_h0", 1, 8'h40, 8'hA0, 1);
        put(1'b1, 8'h47, 8'hB7, 1'b1);
        chk("fullpp_count", 1, 64'(b_count), 64'(4));
        chk_head("fullpp_h1", 1, 8'h41, 8'hA1, 2);
        put(1'b0, 8'h00, 8'h00, 1'b1);
        chk_head("fullpp_h2", 1, 8'h42, 8'hA2, 3);
        put(1'b0, 8'h00, 8'h00, 1'b1);
        chk_head("fullpp_h3", 1, 8'h43, 8'hA3, 4);
        put(1'b0, 8'h00, 8'h00, 1'b1);
        chk_head("fullpp_tail", 1, 8'h47, 8'hB7, 7);
        put(1'b0, 8'h00, 8'h00, 1'b1);
        chk("fullpp_empty", 1, 64'(b_count), 64'(0));

        // DONE write in cycle 10 is captured; a later write is not
        do_reset();
        chk("ovf_cleared", 1, 64'(b_overflow), 64'(1'b0));
        idle_to(10);
        chk("dw_pre_done", 0, 64'(a_done), 64'(1'b0));
        put(1'b1, 8'hFF, 8'h5A, 1'b0);
        chk("dw_done", 0, 64'(a_done), 64'(1'b1));
        chk("dw_cause", 0, 64'(a_done_cause), 64'(2'b01));
        put(1'b0, 8'h00, 8'h00, 1'b0);
        put(1'b1, 8'h03, 8'h33, 1'b0);
        chk("dw_count", 0, 64'(a_count), 64'(1));
        chk_head("dw_head", 0, 8'hFF, 8'h5A, 10);

        // Cycle limit alone, then limit and DONE write in the same cycle
        do_reset();
        idle_to(20);
        chk("lim_pre", 1, 64'(b_done), 64'(1'b0));
        put(1'b0, 8'h00, 8'h00, 1'b0);
        chk("lim_done", 1, 64'(b_done), 64'(1'b1));
        chk("lim_cause", 1, 64'(b_done_cause), 64'(2'b10));
        do_reset();
        idle_to(20);
        put(1'b1, 8'hFF, 8'h00, 1'b0);
        chk("both_cause", 1, 64'(b_done_cause), 64'(2'b11));
        chk("both_a_cause", 0, 64'(a_done_cause), 64'(2'b01));
        chk_head("both_a_head", 0, 8'hFF, 8'h00, 20);

        // One-edge reset while count=3 and done=1
        do_reset();
        idle_to(1);
        put(1'b1, 8'h40, 8'h01, 1'b0);
        put(1'b1, 8'h41, 8'h02, 1'b0);
        put(1'b1, 8'hFF, 8'h03, 1'b0);
        chk("mid_count", 0, 64'(a_count), 64'(3));
        chk("mid_done", 0, 64'(a_done), 64'(1'b1));
        reset = 1'b0;
        put(1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b1;
        chk("mid_rst_count", 0, 64'(a_count), 64'(0));
        chk("mid_rst_valid", 0, 64'(a_rd_valid), 64'(1'b0));
        chk("mid_rst_done", 0, 64'(a_done), 64'(1'b0));
        chk("mid_rst_ovf", 0, 64'(a_overflow), 64'(1'b0));
        put(1'b1, 8'h03, 8'h77, 1'b0);
        chk_head("mid_rst_ts0", 0, 8'h03, 8'h77, 0);

        // Randomised segments, checked every cycle by the model
        for (int s = 0; s < 8; s++) begin
            do_reset();
            for (int n = 0; n < 40; n++) begin
                case ($urandom % 16)
                    0: pick = 8'h03;
                    1: pick = 8'h41;
                    2: pick = 8'h4F;
                    3: pick = 8'h13;
                    4: pick = 8'h43;
                    5: pick = 8'hFF;
                    6: pick = 8'h52;
                    default: pick = 8'($urandom);
                endcase
                put(1'($urandom % 2), pick, 8'($urandom), 1'($urandom % 3 == 0));
            end
        end
        @(negedge clk);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_trace_monitor.md
Name: port_trace_monitor

Overview:
Parametrised, synthesizable successor to the simulation-only processor harness. It watches a KCPSM3-style output bus (port_id, out_port, write_strobe), timestamps every write whose port_id matches a mask, and buffers the writes in a FIFO. A bench or a debug UART drains the FIFO. It raises a sticky done flag when the program writes the DONE port or a cycle limit expires, so the bench no longer needs a fixed-delay $finish.

Parameters:
DATA_W, 8, out_port width
PORT_W, 8, port_id width
TS_W, 16, timestamp/cycle counter width
DEPTH, 16, FIFO entries; power of two, >= 2
MATCH_ID, 8'h00, port_id compare value
MATCH_MASK, 8'h00, port_id bits compared (0 = capture every port)
DONE_ID, 8'hFF, port_id whose write ends the trace
CYCLE_LIMIT, 50, cycle count that forces done; 0 disables the limit

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
port_id  in  PORT_W  processor port address
out_port  in  DATA_W  processor output data
write_strobe  in  1  output write qualifier
rd_en  in  1  pop request
rd_valid  out  1  FIFO non-empty; head entry is presented
rd_port_id  out  PORT_W  head entry port_id
rd_data  out  DATA_W  head entry data
rd_ts  out  TS_W  head entry timestamp
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; a matching write was dropped because the FIFO was full
done  out  1  sticky end-of-trace flag
done_cause  out  2  00 none, 01 DONE write, 10 cycle limit, 11 both in the same cycle

Behaviour:
- Reset (reset==0 at a clock edge): cyc=0, FIFO empty, count=0, rd_valid=0, rd_* = 0, overflow=0, done=0, done_cause=00. Reset asserted mid-trace discards all entries.
- cyc: 0 in the first cycle after reset is released. Increments each edge and saturates at 2^TS_W-1 (no wrap).
- Match: write_strobe && ((port_id & MATCH_MASK) == (MATCH_ID & MATCH_MASK)) && !done.
- Push: on a match, the entry {port_id, out_port, cyc} is written at that edge. The entry's ts is the cyc value of the strobe cycle.
- Latency: a write in cycle k sets rd_valid and shows the entry on rd_* in cycle k+1 (first-word-fall-through; rd_* come straight from the FIFO registers).
- Pop: rd_en && rd_valid advances the head at the edge. rd_en while empty is ignored with no side effects.
- Full: a matching write when count==DEPTH and no pop in the same cycle is dropped, and overflow is set. If full and a pop and a push occur in the same cycle, both take effect and count stays DEPTH.
- Empty: a simultaneous push and pop on an empty FIFO performs the push only (rd_valid was 0).
- count updates at the same edge as the push/pop; it covers the range 0..DEPTH inclusive.
- Done on DONE write: write_strobe && port_id==DONE_ID, independent of MATCH_MASK. done rises at the next edge.
- Done on cycle limit: if CYCLE_LIMIT!=0 and cyc==CYCLE_LIMIT, done rises at the next edge.
- done_cause is set only on the 0->1 transition of done; 11 if both causes occur in that cycle.
- The DONE write is itself captured if it matches, because done is still 0 in that cycle.
- After done: no further captures and cyc freezes. Reads continue until the FIFO is empty. overflow and done hold until reset.
- Pointers are log2(DEPTH) bits with natural wrap. Full/empty are derived from count.

Decomposition:
- Package port_trace_pkg:
  - done_cause localparams: CAUSE_NONE, CAUSE_DONE, CAUSE_LIMIT, CAUSE_BOTH.
  - Entry packing width function: PORT_W+DATA_W+TS_W.
  - Packing/unpacking field offsets.
- Sub-module sync_fifo_fwft:
  - Parametrised WIDTH and DEPTH, synchronous active-low reset.
  - Ports: push, pop, din, dout, count, full, empty.
  - Simultaneous push/pop behaviour exactly as specified above.
- Top level contains: match logic, cycle counter, done/overflow flags.

Test Plan:
- MASK=0: writes 0x11 to port 0x03 in cycle 4 and 0x22 to port 0x07 in cycle 6 -> rd_valid in cycle 5. Pops return (03,11,ts=4) then (07,22,ts=6), then rd_valid=0 and count=0.
- MATCH_ID=0x40, MASK=0xF0: writes to 0x41, 0x52, 0x4F -> only 0x41 and 0x4F are captured, in order; count=2.
- DEPTH=4: six matching writes with no pops -> count=4, overflow=1, and the entries held are the first four. A push and a pop in the same cycle while full -> count stays 4, and the new entry sits at the tail.
- Program writes 0x5A to DONE_ID=0xFF in cycle 10 (MASK=0) -> done=1 and done_cause=01 from cycle 11. The 0xFF entry is captured; a later write in cycle 12 is not captured.
- CYCLE_LIMIT=20 with no DONE write -> done=1 and done_cause=10 in cycle 21; cyc frozen. A DONE write in cycle 20 -> done_cause=11.
- Reset pulsed low for one edge while count=3 and done=1 -> the next cycle has count=0, rd_valid=0, done=0, overflow=0, and cyc restarts at 0.
